pc_controller: RTL and testbench

PC_CONTROLLER -- requirements
Module: pc_controller

---
 rtl/pc_controller_if.sv | 25 ++
 rtl/pc_controller.sv | 89 ++++++++
 tb/tb_pc_controller.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/pc_controller_if.sv
// rtl/pc_controller_if.sv - fetch/redirect bus between the pipeline and the PC controller
interface pc_controller_if;
  logic [31:0] instruction_address;
  logic        hit;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        pc_enable;
  logic [31:0] next_instruction_address;
  logic        flush;
  logic [1:0]  state;
  logic        miss_timeout;

  modport master (
    output instruction_address, hit, stall, branch_taken, branch_target, jump, jump_target,
    input  pc_enable, next_instruction_address, flush, state, miss_timeout
  );

  modport slave (
    input  instruction_address, hit, stall, branch_taken, branch_target, jump, jump_target,
    output pc_enable, next_instruction_address, flush, state, miss_timeout
  );
endinterface

// File: rtl/pc_controller.sv
// rtl/pc_controller.sv - PC sequencing FSM with pending redirect capture and miss timeout
module pc_controller #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned MISS_TIMEOUT = 16
) (
  input logic            clock,
  input logic            reset,
  pc_controller_if.slave bus
);
  localparam int unsigned CW = $clog2(MISS_TIMEOUT + 1);
  localparam logic [CW-1:0] MISS_MAX = CW'(MISS_TIMEOUT);

  typedef enum logic [1:0] {RUN = 2'd0, MISS = 2'd1, FLUSH = 2'd2} state_t;

  state_t        state_q, state_d;
  logic          pending_valid, pending_valid_d;
  logic [31:0]   pending_target, pending_target_d;
  logic [CW-1:0] miss_count, miss_count_d;
  logic          timeout_q, timeout_d;

  logic          redirect_req;
  logic [31:0]   redirect_target;
  logic          advance;
  logic          apply_valid;
  logic [31:0]   addr;

  always_comb begin
    redirect_req     = bus.jump | bus.branch_taken;
    redirect_target  = bus.jump ? bus.jump_target : bus.branch_target;
    advance          = (state_q == RUN) && bus.hit && !bus.stall;
    apply_valid      = pending_valid | redirect_req;

    // The oldest captured redirect outranks anything arriving later.
    if (pending_valid)     addr = pending_target;
    else if (redirect_req) addr = redirect_target;
    else                   addr = bus.instruction_address + 32'd4;

    state_d          = state_q;
    pending_valid_d  = pending_valid;
    pending_target_d = pending_target;
    miss_count_d     = miss_count;
    timeout_d        = timeout_q;

    if (advance && apply_valid) begin
      pending_valid_d = 1'b0;
    end else if (!pending_valid && redirect_req) begin
      pending_valid_d  = 1'b1;
      pending_target_d = redirect_target;
    end

    case (state_q)
      RUN: begin
        miss_count_d = '0;
        if (!bus.hit)                    state_d = MISS;
        else if (advance && apply_valid) state_d = FLUSH;
      end
      MISS: begin
        if (miss_count != MISS_MAX) miss_count_d = miss_count + CW'(1);
        if (miss_count_d == MISS_MAX) timeout_d = 1'b1;
        if (bus.hit) state_d = RUN;
      end
      FLUSH:   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= RUN;
      pending_valid  <= 1'b0;
      pending_target <= '0;
      miss_count     <= '0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      pending_valid  <= pending_valid_d;
      pending_target <= pending_target_d;
      miss_count     <= miss_count_d;
      timeout_q      <= timeout_d;
    end
  end

  // Reset overrides outputs combinationally so the reset-cycle view is fixed.
  assign bus.pc_enable                = reset | advance;
  assign bus.next_instruction_address = reset ? RESET_VECTOR : addr;
  assign bus.flush                    = !reset && (state_q == FLUSH);
  assign bus.state                    = reset ? RUN : state_q;
  assign bus.miss_timeout             = !reset && timeout_q;
endmodule

// File: tb/tb_pc_controller.sv
// tb/tb_pc_controller.sv - directed self-checking bench for pc_controller
module tb_pc_controller;
  localparam logic [31:0] RV = 32'h0000_1000;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;

  pc_controller_if bus ();

  pc_controller #(.RESET_VECTOR(RV), .MISS_TIMEOUT(16)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic h, input logic s,
                       input logic b, input logic [31:0] bt,
                       input logic j, input logic [31:0] jt);
    bus.instruction_address = pc;
    bus.hit = h;
    bus.stall = s;
    bus.branch_taken = b;
    bus.branch_target = bt;
    bus.jump = j;
    bus.jump_target = jt;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(32'h0000_0abc, 1'b0, 1'b1, 1'b1, 32'h0000_0444, 1'b1, 32'h0000_0888);
    tick();
    checks++; if (bus.state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", bus.state); end
    checks++; if (bus.pc_enable !== 1'b1) begin failures++; $display("FAIL reset_pc_enable got=%b exp=1", bus.pc_enable); end
    checks++; if (bus.next_instruction_address !== RV) begin failures++; $display("FAIL reset_next got=%h exp=%h", bus.next_instruction_address, RV); end
    checks++; if (bus.flush !== 1'b0) begin failures++; $display("FAIL reset_flush got=%b exp=0", bus.flush); end
    checks++; if (bus.miss_timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%b exp=0", bus.miss_timeout); end
    reset = 1'b0;
  endtask

  task automatic test_sequential();
    drive(32'h0000_0100, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++; if (bus.pc_enable !== 1'b1) begin failures++; $display("FAIL seq_pc_enable got=%b exp=1", bus.pc_enable); end
    checks++; if (bus.next_instruction_address !== 32'h0000_0104) begin failures++; $display("FAIL seq_next got=%h exp=00000104", bus.next_instruction_address); end
    tick();
    checks++; if (bus.state !== 2'd0) begin failures++; $display("FAIL seq_state got=%0d exp=0", bus.state); end
    checks++; if (bus.flush !== 1'b0) begin failures++; $display("FAIL seq_flush got=%b exp=0", bus.flush); end
  endtask

  task automatic test_redirect();
    drive(32'h0000_0200, 1'b1, 1'b0, 1'b1, 32'h0000_0400, 1'b1, 32'h0000_0800);
    checks++; if (bus.next_instruction_address !== 32'h0000_0800) begin failures++; $display("FAIL redir_next got=%h exp=00000800", bus.next_instruction_address); end
    checks++; if (bus.pc_enable !== 1'b1) begin failures++; $display("FAIL redir_pc_enable got=%b exp=1", bus.pc_enable); end
    tick();
    drive(32'h0000_0800, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++; if (bus.state !== 2'd2) begin failures++; $display("FAIL redir_flush_state got=%0d exp=2", bus.state); end
    checks++; if (bus.flush !== 1'b1) begin failures++; $display("FAIL redir_flush got=%b exp=1", bus.flush); end
    checks++; if (bus.pc_enable !== 1'b0) begin failures++; $display("FAIL redir_flush_pc_enable got=%b exp=0", bus.pc_enable); end
    tick();
    checks++; if (bus.state !== 2'd0) begin failures++; $display("FAIL redir_back_run got=%0d exp=0", bus.state); end
    checks++; if (bus.flush !== 1'b0) begin failures++; $display("FAIL redir_flush_drop got=%b exp=0", bus.flush); end
  endtask

  task automatic test_miss_redirect();
    drive(32'h0000_0300, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++; if (bus.pc_enable !== 1'b0) begin failures++; $display("FAIL mr_c1_pc_enable got=%b exp=0", bus.pc_enable); end
    tick();
    drive(32'h0000_0300, 1'b0, 1'b0, 1'b1, 32'h0000_0040, 1'b0, 32'h0);
    checks++; if (bus.state !== 2'd1) begin failures++; $display("FAIL mr_c2_state got=%0d exp=1", bus.state); end
    checks++; if (bus.pc_enable !== 1'b0) begin failures++; $display("FAIL mr_c2_pc_enable got=%b exp=0", bus.pc_enable); end
    tick();
    drive(32'h0000_0300, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++; if (bus.state !== 2'd1) begin failures++; $display("FAIL mr_c3_state got=%0d exp=1", bus.state); end
    checks++; if (bus.next_instruction_address !== 32'h0000_0040) begin failures++; $display("FAIL mr_c3_pending got=%h exp=00000040", bus.next_instruction_address); end
    tick();
    drive(32'h0000_0300, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++; if (bus.state !== 2'd1) begin failures++; $display("FAIL mr_c4_state got=%0d exp=1", bus.state); end
    checks++; if (bus.pc_enable !== 1'b0) begin failures++; $display("FAIL mr_c4_pc_enable got=%b exp=0", bus.pc_enable); end
    tick();
    checks++; if (bus.state !== 2'd0) begin failures++; $display("FAIL mr_c5_state got=%0d exp=0", bus.state); end
    checks++; if (bus.pc_enable !== 1'b1) begin failures++; $display("FAIL mr_c5_pc_enable got=%b exp=1", bus.pc_enable); end
    checks++; if (bus.next_instruction_address !== 32'h0000_0040) begin failures++; $display("FAIL mr_c5_next got=%h exp=00000040", bus.next_instruction_address); end
    tick();
    checks++; if (bus.flush !== 1'b1) begin failures++; $display("FAIL mr_flush got=%b exp=1", bus.flush); end
    tick();
    checks++; if (bus.next_instruction_address !== 32'h0000_0304) begin failures++; $display("FAIL mr_pending_cleared got=%h exp=00000304", bus.next_instruction_address); end
  endtask

  task automatic test_timeout();
    logic exp_to;
    for (int i = 0; i < 20; i++) begin
      drive(32'h0000_0500, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      exp_to = (i >= 17);
      checks++; if (bus.miss_timeout !== exp_to) begin failures++; $display("FAIL to_cycle%0d got=%b exp=%b", i, bus.miss_timeout, exp_to); end
      tick();
    end
    drive(32'h0000_0500, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    tick();
    checks++; if (bus.state !== 2'd0) begin failures++; $display("FAIL to_run_state got=%0d exp=0", bus.state); end
    checks++; if (bus.miss_timeout !== 1'b1) begin failures++; $display("FAIL to_sticky got=%b exp=1", bus.miss_timeout); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checks++; if (bus.miss_timeout !== 1'b0) begin failures++; $display("FAIL to_cleared got=%b exp=0", bus.miss_timeout); end
  endtask

  task automatic test_stall_two_redirects();
    drive(32'h0000_0300, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_0500);
    checks++; if (bus.pc_enable !== 1'b0) begin failures++; $display("FAIL st_pc_enable got=%b exp=0", bus.pc_enable); end
    tick();
    drive(32'h0000_0300, 1'b1, 1'b1, 1'b1, 32'h0000_0600, 1'b0, 32'h0);
    checks++; if (bus.next_instruction_address !== 32'h0000_0500) begin failures++; $display("FAIL st_second_ignored got=%h exp=00000500", bus.next_instruction_address); end
    tick();
    drive(32'h0000_0300, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++; if (bus.pc_enable !== 1'b1) begin failures++; $display("FAIL st_release_pc_enable got=%b exp=1", bus.pc_enable); end
    checks++; if (bus.next_instruction_address !== 32'h0000_0500) begin failures++; $display("FAIL st_release_next got=%h exp=00000500", bus.next_instruction_address); end
    tick();
    checks++; if (bus.state !== 2'd2) begin failures++; $display("FAIL st_flush_state got=%0d exp=2", bus.state); end
    tick();
  endtask

  task automatic test_stall_miss();
    drive(32'h0000_0700, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    checks++; if (bus.state !== 2'd1) begin failures++; $display("FAIL sm_state got=%0d exp=1", bus.state); end
    drive(32'h0000_0700, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
  endtask

  task automatic test_wrap_reset();
    drive(32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++; if (bus.next_instruction_address !== 32'h0000_0000) begin failures++; $display("FAIL wrap_next got=%h exp=00000000", bus.next_instruction_address); end
    checks++; if (bus.pc_enable !== 1'b1) begin failures++; $display("FAIL wrap_pc_enable got=%b exp=1", bus.pc_enable); end
    tick();
    drive(32'h0000_0010, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    drive(32'h0000_0010, 1'b0, 1'b0, 1'b1, 32'h0000_0900, 1'b0, 32'h0);
    checks++; if (bus.state !== 2'd1) begin failures++; $display("FAIL wr_in_miss got=%0d exp=1", bus.state); end
    tick();
    reset = 1'b1;
    #1;
    checks++; if (bus.state !== 2'd0) begin failures++; $display("FAIL wr_reset_state got=%0d exp=0", bus.state); end
    checks++; if (bus.next_instruction_address !== RV) begin failures++; $display("FAIL wr_reset_next got=%h exp=%h", bus.next_instruction_address, RV); end
    tick();
    reset = 1'b0;
    drive(32'h0000_0010, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++; if (bus.next_instruction_address !== 32'h0000_0014) begin failures++; $display("FAIL wr_pending_discarded got=%h exp=00000014", bus.next_instruction_address); end
    checks++; if (bus.state !== 2'd0) begin failures++; $display("FAIL wr_after_state got=%0d exp=0", bus.state); end
    tick();
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_redirect();
    test_miss_redirect();
    test_timeout();
    test_stall_two_redirects();
    test_stall_miss();
    test_wrap_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
